// File: rtl/cpu_mem_loader.sv
// Host-side loader for the CPU's external memory ports: streams commands in, writes
// instruction/data memory, runs the CPU for N cycles, and dumps data memory back out.
module cpu_mem_loader #(
  parameter int CNT_W  = 16,
  parameter int IDX_W  = 12,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic        m_valid,
  output logic [31:0] m_data,
  input  logic        m_ready,
  output logic        enable,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  input  logic [31:0] rdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // Stream handshake: a beat moves on a rising edge where valid && ready; the
  // outbound side holds m_valid/m_data stable until m_ready.

  localparam int SUM_W = IDX_W + CNT_W;
  localparam int LAT_W = 8;

  typedef enum logic [3:0] {
    S_IDLE, S_LD_I, S_LD_D, S_RUN, S_RD, S_WAIT, S_TX_LO, S_TX_HI
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [31:0]        lo_q, lo_d;
  logic               hi_q, hi_d;
  logic [63:0]        rdata_q, rdata_d;
  logic               enable_q, enable_d;
  logic               wen_q, wen_d;
  logic [63:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               wen2_q, wen2_d;
  logic [63:0]        addr2_q, addr2_d;
  logic [63:0]        wdata2_q, wdata2_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               live_q;
  logic               accept;
  logic [CNT_W-1:0]   k_inc;
  logic               unused_rdata;

  function automatic logic [SUM_W-1:0] word_idx(input logic [IDX_W-1:0] b,
                                                 input logic [CNT_W-1:0] k);
    return SUM_W'(b) + SUM_W'(k);
  endfunction

  function automatic logic [63:0] word_addr(input logic [IDX_W-1:0] b,
                                            input logic [CNT_W-1:0] k);
    return 64'({word_idx(b, k), 2'b00});
  endfunction

  function automatic logic [63:0] dword_addr(input logic [IDX_W-1:0] b,
                                             input logic [CNT_W-1:0] k);
    return 64'({word_idx(b, k), 3'b000});
  endfunction

  assign unused_rdata = ^rdata_ext;
  assign k_inc = k_q + CNT_W'(1);

  // live_q keeps s_ready low while reset is asserted and for the first edge after it.
  always_comb begin
    s_ready = 1'b0;
    if (live_q) begin
      if (state_q == S_IDLE) s_ready = 1'b1;
      else if ((state_q == S_LD_I || state_q == S_LD_D) && k_q != n_q) s_ready = 1'b1;
    end
  end

  assign accept      = s_valid && s_ready;
  assign ren_ext     = 1'b0;
  assign ren_ext_2   = (state_q == S_RD);
  assign m_valid     = (state_q == S_TX_LO) || (state_q == S_TX_HI);
  assign m_data      = (state_q == S_TX_HI) ? rdata_q[63:32] : rdata_q[31:0];
  assign busy        = (state_q != S_IDLE);
  assign enable      = enable_q;
  assign wen_ext     = wen_q;
  assign addr_ext    = addr_q;
  assign wdata_ext   = wdata_q;
  assign wen_ext_2   = wen2_q;
  assign addr_ext_2  = addr2_q;
  assign wdata_ext_2 = wdata2_q;
  assign done        = done_q;
  assign err         = err_q;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    n_d      = n_q;
    k_d      = k_q;
    lat_d    = lat_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    addr2_d  = addr2_q;
    wdata2_d = wdata2_q;
    enable_d = 1'b0;
    wen_d    = 1'b0;
    wen2_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          base_d = s_data[27:16];
          n_d    = CNT_W'(s_data[15:0]);
          k_d    = '0;
          hi_d   = 1'b0;
          lat_d  = '0;
          if (s_data[31:28] >= 4'd1 && s_data[31:28] <= 4'd4) begin
            if (s_data[15:0] == 16'd0) begin
              done_d = 1'b1;
            end else begin
              case (s_data[31:28])
                4'd1:    state_d = S_LD_I;
                4'd2:    state_d = S_LD_D;
                4'd3:    begin state_d = S_RUN; enable_d = 1'b1; end
                default: begin state_d = S_RD; addr2_d = dword_addr(s_data[27:16], '0); end
              endcase
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LD_I: begin
        if (accept) begin
          wen_d   = 1'b1;
          addr_d  = word_addr(base_q, k_q);
          wdata_d = s_data;
          k_d     = k_inc;
        end else if (k_q == n_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_LD_D: begin
        if (accept) begin
          if (!hi_q) begin
            lo_d = s_data;
            hi_d = 1'b1;
          end else begin
            wen2_d   = 1'b1;
            addr2_d  = dword_addr(base_q, k_q);
            wdata2_d = {s_data, lo_q};
            k_d      = k_inc;
            hi_d     = 1'b0;
          end
        end else if (k_q == n_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        k_d = k_inc;
        if (k_inc == n_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          enable_d = 1'b1;
        end
      end
      S_RD: begin
        lat_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == LAT_W'(RD_LAT - 1)) begin
          rdata_d = rdata_ext_2;
          state_d = S_TX_LO;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_TX_LO: begin
        if (m_ready) state_d = S_TX_HI;
      end
      S_TX_HI: begin
        if (m_ready) begin
          k_d = k_inc;
          if (k_inc == n_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            addr2_d = dword_addr(base_q, k_inc);
            state_d = S_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      n_q      <= '0;
      k_q      <= '0;
      lat_q    <= '0;
      lo_q     <= '0;
      hi_q     <= 1'b0;
      rdata_q  <= '0;
      enable_q <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wen2_q   <= 1'b0;
      addr2_q  <= '0;
      wdata2_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      n_q      <= n_d;
      k_q      <= k_d;
      lat_q    <= lat_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      rdata_q  <= rdata_d;
      enable_q <= enable_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wen2_q   <= wen2_d;
      addr2_q  <= addr2_d;
      wdata2_q <= wdata2_d;
      done_q   <= done_d;
      err_q    <= err_d;
      live_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Directed bench for cpu_mem_loader: stimulus pushes expected events into queues and
// a negedge monitor pops and compares them as the DUT produces writes, reads and pulses.
module tb_cpu_mem_loader;

  logic        clk, arst_n;
  logic        s_valid, s_ready, m_valid, m_ready, enable;
  logic [31:0] s_data, m_data, wdata_ext, rdata_ext;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2, busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] imem_q[$];
  logic [95:0] dmem_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] m_q[$];
  logic [15:0] run_q[$];
  logic [1:0]  ev_q[$];

  logic [63:0] mem [0:7];

  cpu_mem_loader #(.CNT_W(16), .IDX_W(12), .RD_LAT(1)) dut (
    .clk(clk), .arst_n(arst_n),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .enable(enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .busy(busy), .done(done), .err(err)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2 m_ready = ~m_ready;
    end
  end

  // data memory model, one-cycle read latency
  always @(posedge clk) begin
    if (ren_ext_2) rdata_ext_2 <= mem[addr_ext_2[5:3]];
    if (wen_ext_2) mem[addr_ext_2[5:3]] <= wdata_ext_2;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  int          en_len = 0;
  logic        prev_en = 1'b0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_data = '0;

  always @(negedge clk) begin
    if (hold_pend) begin
      chk("m_hold_valid", 128'(m_valid), 128'(1));
      chk("m_hold_data", 128'(m_data), 128'(hold_data));
    end
    hold_pend = m_valid && !m_ready;
    hold_data = m_data;

    if (wen_ext || wen_ext_2 || ren_ext_2)
      chk("strobe_excl", 128'($onehot0({wen_ext, wen_ext_2, ren_ext_2})), 128'(1));
    if (done && err) chk("done_err_excl", 128'(1), 128'(0));
    if (done || err) begin
      if (ev_q.size() == 0) chk("unexpected_pulse", 128'({done, err}), 128'(0));
      else chk("pulse", 128'({err, done}), 128'(ev_q.pop_front()));
    end
    if (wen_ext) begin
      if (imem_q.size() == 0) chk("unexpected_imem_wr", 128'({addr_ext[31:0], wdata_ext}), 128'(0));
      else chk("imem_wr", 128'({addr_ext[31:0], wdata_ext}), 128'(imem_q.pop_front()));
    end
    if (wen_ext_2) begin
      if (dmem_q.size() == 0) chk("unexpected_dmem_wr", 128'({addr_ext_2[31:0], wdata_ext_2}), 128'(0));
      else chk("dmem_wr", 128'({addr_ext_2[31:0], wdata_ext_2}), 128'(dmem_q.pop_front()));
    end
    if (ren_ext_2) begin
      if (rd_q.size() == 0) chk("unexpected_rd", 128'(addr_ext_2), 128'(0));
      else chk("rd_addr", 128'(addr_ext_2), 128'(rd_q.pop_front()));
    end
    if (m_valid && m_ready) begin
      if (m_q.size() == 0) chk("unexpected_m_beat", 128'(m_data), 128'(0));
      else chk("m_data", 128'(m_data), 128'(m_q.pop_front()));
    end
    chk("ren_ext_zero", 128'(ren_ext), 128'(0));
    if (enable) begin
      en_len++;
      if (wen_ext || wen_ext_2 || ren_ext_2) chk("strobe_during_enable", 128'(1), 128'(0));
    end else if (prev_en) begin
      if (run_q.size() == 0) chk("unexpected_enable", 128'(en_len), 128'(0));
      else chk("enable_len", 128'(en_len), 128'(run_q.pop_front()));
      chk("done_at_enable_fall", 128'(done), 128'(1));
      en_len = 0;
    end
    prev_en = enable;
  end

  // driver tasks
  task automatic send(input logic [31:0] w);
    int t = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: word %h not accepted, got s_ready=0 required 1", w);
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int t = 0;
    while (t < 500 && (busy || ev_q.size() != 0 || imem_q.size() != 0 ||
                       dmem_q.size() != 0 || m_q.size() != 0 || rd_q.size() != 0 ||
                       run_q.size() != 0)) begin
      @(posedge clk);
      #3;
      t++;
    end
    chk({name, "_complete"}, 128'(t < 500), 128'(1));
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic any_out();
    return |{s_ready, m_valid, m_data, enable, addr_ext, wen_ext, ren_ext, wdata_ext,
             addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, busy, done, err};
  endfunction

  initial begin
    arst_n      = 1'b0;
    s_valid     = 1'b0;
    s_data      = '0;
    rdata_ext   = '0;
    rdata_ext_2 = '0;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    #1 chk("reset_outputs", 128'(any_out()), 128'(0));
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1 chk("idle_ready", 128'({s_ready, busy}), 128'(2'b10));

    // reset after only the low beat of a doubleword
    send(32'h2000_0001);
    send(32'hCAFE_F00D);
    #2 arst_n = 1'b0;
    #1 chk("midreset_outputs", 128'(any_out()), 128'(0));
    repeat (3) begin
      @(negedge clk);
      chk("reset_held_outputs", 128'(any_out()), 128'(0));
    end
    arst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("post_reset_idle", 128'({s_ready, busy}), 128'(2'b10));

    // LOAD_IMEM base=2 N=3
    imem_q.push_back({32'd8,  32'h0050_0093});
    imem_q.push_back({32'd12, 32'h00A0_0113});
    imem_q.push_back({32'd16, 32'h0020_81B3});
    ev_q.push_back(2'b01);
    send(32'h1002_0003);
    send(32'h0050_0093);
    send(32'h00A0_0113);
    send(32'h0020_81B3);
    wait_quiet("load_imem");

    // LOAD_DMEM base=0 N=1
    dmem_q.push_back({32'd0, 64'h0123_4567_DEAD_BEEF});
    ev_q.push_back(2'b01);
    send(32'h2000_0001);
    send(32'hDEAD_BEEF);
    send(32'h0123_4567);
    wait_quiet("load_dmem");
    chk("dmem_model_word0", 128'(mem[0]), 128'(64'h0123_4567_DEAD_BEEF));

    // RUN N=5, then RUN N=0
    run_q.push_back(16'd5);
    ev_q.push_back(2'b01);
    send(32'h3000_0005);
    wait_quiet("run5");
    ev_q.push_back(2'b01);
    send(32'h3000_0000);
    wait_quiet("run0");

    // DUMP base=1 N=2 under m_ready toggling
    mem[1] = 64'h1111_2222_3333_4444;
    mem[2] = 64'h5555_6666_7777_8888;
    rd_q.push_back(32'd8);
    rd_q.push_back(32'd16);
    m_q.push_back(32'h3333_4444);
    m_q.push_back(32'h1111_2222);
    m_q.push_back(32'h7777_8888);
    m_q.push_back(32'h5555_6666);
    ev_q.push_back(2'b01);
    send(32'h4001_0002);
    wait_quiet("dump");

    // unknown opcode, then a normal command
    ev_q.push_back(2'b10);
    send(32'hF000_0004);
    wait_quiet("bad_opcode");
    imem_q.push_back({32'h40, 32'h1234_5678});
    ev_q.push_back(2'b01);
    send(32'h1010_0001);
    send(32'h1234_5678);
    wait_quiet("load_after_err");

    // LOAD_IMEM with N=0 only pulses done
    ev_q.push_back(2'b01);
    send(32'h1005_0000);
    wait_quiet("load_n0");

    chk("queues_drained", 128'(imem_q.size() + dmem_q.size() + rd_q.size() + m_q.size() +
                               run_q.size() + ev_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
